// File: rtl/mux4.sv
// rtl/mux4.sv - registered 4-to-1 multiplexer with one-cycle latency
// Optional MUX4_CHG_EN adds sel_chg, a one-cycle flag raised when the sampled select index changes.
module mux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
`ifdef MUX4_CHG_EN
  output logic             sel_chg,
`endif
  output logic [WIDTH-1:0] Output
);

  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_out;

  assign w_sel = {s1, s0};

  always_comb begin
    w_mux = I0;
    case (w_sel)
      2'b00:   w_mux = I0;
      2'b01:   w_mux = I1;
      2'b10:   w_mux = I2;
      2'b11:   w_mux = I3;
      default: w_mux = I0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_mux;
    end
  end

  assign Output = r_out;

`ifdef MUX4_CHG_EN
  logic [1:0] r_prev_sel;
  logic       r_sel_chg;

  // The first sample after reset is compared against index 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_sel <= 2'b00;
      r_sel_chg  <= 1'b0;
    end else begin
      r_prev_sel <= w_sel;
      r_sel_chg  <= (w_sel != r_prev_sel);
    end
  end

  assign sel_chg = r_sel_chg;
`endif

endmodule

// File: tb/tb_mux4.sv
// tb/tb_mux4.sv - scoreboard bench for mux4 at WIDTH=1 and WIDTH=8
module tb_mux4;

  logic       clk;
  logic       rst;
  logic       s0;
  logic       s1;
  logic [0:0] d1 [4];
  logic [7:0] d8 [4];
  logic [0:0] o1;
  logic [7:0] o8;
`ifdef MUX4_CHG_EN
  logic       chg1;
  logic       chg8;
`endif

  int checks;
  int failures;

  logic [0:0] q1 [$];
  logic [7:0] q8 [$];

  mux4 #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .s0     (s0),
    .s1     (s1),
    .I0     (d1[0]),
    .I1     (d1[1]),
    .I2     (d1[2]),
    .I3     (d1[3]),
`ifdef MUX4_CHG_EN
    .sel_chg(chg1),
`endif
    .Output (o1)
  );

  mux4 #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .s0     (s0),
    .s1     (s1),
    .I0     (d8[0]),
    .I1     (d8[1]),
    .I2     (d8[2]),
    .I3     (d8[3]),
`ifdef MUX4_CHG_EN
    .sel_chg(chg8),
`endif
    .Output (o8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [1:0] sel, input string name);
    logic [0:0] e1;
    logic [7:0] e8;
    @(negedge clk);
    s1 = sel[1];
    s0 = sel[0];
    q1.push_back(d1[sel]);
    q8.push_back(d8[sel]);
    @(posedge clk);
    #1;
    e1 = q1.pop_front();
    e8 = q8.pop_front();
    checks++;
    if (o1 !== e1) begin
      failures++;
      $display("FAIL %s w1 sel=%b: got %h expected %h", name, sel, o1, e1);
    end
    checks++;
    if (o8 !== e8) begin
      failures++;
      $display("FAIL %s w8 sel=%b: got %h expected %h", name, sel, o8, e8);
    end
  endtask

  task automatic test_reset();
    s0 = 1'b0;
    s1 = 1'b0;
    rst = 1'b0;
    d1[0] = 1'b1; d1[1] = 1'b0; d1[2] = 1'b1; d1[3] = 1'b0;
    d8[0] = 8'hA5; d8[1] = 8'h3C; d8[2] = 8'hFF; d8[3] = 8'h00;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (o1 !== 1'b0 || o8 !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: got %h/%h expected 0/00", o1, o8);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o1 !== 1'b0 || o8 !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold: got %h/%h expected 0/00", o1, o8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    step(2'b00, "sweep00");
    step(2'b10, "sweep10");
    step(2'b01, "sweep01");
    step(2'b11, "sweep11");
    step(2'b00, "sweep8_00");
    step(2'b01, "sweep8_01");
    step(2'b10, "sweep8_10");
    step(2'b11, "sweep8_11");
  endtask

  task automatic test_latency();
    step(2'b00, "lat_pre");
    @(negedge clk);
    s1 = 1'b1;
    s0 = 1'b1;
    q1.push_back(d1[3]);
    q8.push_back(d8[3]);
    #2;
    checks++;
    if (o1 !== 1'b1 || o8 !== 8'hA5) begin
      failures++;
      $display("FAIL lat_hold: got %h/%h expected 1/a5", o1, o8);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o1 !== q1.pop_front()) begin
      failures++;
      $display("FAIL lat_edge w1: got %h expected 0", o1);
    end
    checks++;
    if (o8 !== q8.pop_front()) begin
      failures++;
      $display("FAIL lat_edge w8: got %h expected 00", o8);
    end
  endtask

  task automatic test_async_mid();
    step(2'b00, "mid_pre");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o1 !== 1'b0 || o8 !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: got %h/%h expected 0/00", o1, o8);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o1 !== 1'b1 || o8 !== 8'hA5) begin
      failures++;
      $display("FAIL mid_reload: got %h/%h expected 1/a5", o1, o8);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      d8[i % 4] = 8'($urandom);
      d1[(i + 1) % 4] = 1'($urandom);
      step(2'($urandom_range(0, 3)), "b2b");
    end
  endtask

`ifdef MUX4_CHG_EN
  task automatic test_sel_chg();
    logic [1:0] seq [5];
    logic       exp [5];
    seq[0] = 2'b00; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b01; seq[4] = 2'b11;
    exp[0] = 1'b0;  exp[1] = 1'b0;  exp[2] = 1'b1;  exp[3] = 1'b0;  exp[4] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (chg1 !== 1'b0 || chg8 !== 1'b0) begin
      failures++;
      $display("FAIL chg_reset: got %b/%b expected 0/0", chg1, chg8);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(seq[i], "chg_data");
      checks++;
      if (chg1 !== exp[i] || chg8 !== exp[i]) begin
        failures++;
        $display("FAIL chg_seq%0d: got %b/%b expected %b", i, chg1, chg8, exp[i]);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sweep();
    test_latency();
    test_async_mid();
    test_back_to_back();
`ifdef MUX4_CHG_EN
    test_sel_chg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
